// File: rtl/ecc_mem_ctrl_if.sv
// Host request/response bus of the SECDED storage controller.
interface ecc_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [12:0]       req_inj_mask;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_sec;
  logic              rsp_ded;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_inj_mask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_sec, rsp_ded
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_inj_mask,
    output req_ready, rsp_valid, rsp_rdata, rsp_sec, rsp_ded
  );
endinterface

// File: rtl/ecc_mem_ctrl.sv
// SECDED-protected 8-bit storage: host reads/writes and a background
// scrubber share one encode/decode path over a 13-bit codeword array.
module ecc_mem_ctrl #(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned SCRUB_INTERVAL = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ecc_mem_ctrl_if.slave        bus,
  input  logic                 scrub_en,
  output logic                 scrub_busy,
  output logic [7:0]           sec_cnt,
  output logic [7:0]           ded_cnt
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW_W  = 13;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RDEC, S_SCRUB_RD, S_SCRUB_CHK, S_SCRUB_WB
  } state_t;

  // Layout: [0]p1 [1]p2 [2]d0 [3]p4 [4..6]d1..d3 [7]p8 [8..11]d4..d7 [12]p0
  function automatic logic [CW_W-1:0] f_encode(input logic [7:0] d);
    logic [CW_W-1:0] c;
    c      = '0;
    c[2]   = d[0];
    c[6:4] = d[3:1];
    c[11:8]= d[7:4];
    c[0]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]   = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]   = d[4] ^ d[5] ^ d[6] ^ d[7];
    c[12]  = ^c[11:0];
    return c;
  endfunction

  function automatic logic [7:0] f_extract(input logic [CW_W-1:0] c);
    return {c[11:8], c[6:4], c[2]};
  endfunction

  state_t            r_state, w_state_nxt;
  logic [CW_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] r_addr, r_scrub_ptr;
  logic [7:0]        r_wdata;
  logic [CW_W-1:0]   r_mask, r_cw;
  logic [TMR_W-1:0]  r_timer;
  logic              r_pending, r_req_ready, r_scrub_busy;
  logic              r_rsp_valid, r_rsp_sec, r_rsp_ded;
  logic [7:0]        r_rsp_rdata, r_sec_cnt, r_ded_cnt;

  logic              w_hs, w_scrub_start, w_scrub_exit, w_fire, w_pending_nxt;
  logic [3:0]        w_syn;
  logic              w_pe, w_sec, w_ded;
  logic [CW_W-1:0]   w_fixed;
  logic [7:0]        w_data;

  // Syndrome decode of the registered codeword
  always_comb begin
    w_syn   = '0;
    w_fixed = r_cw;
    w_sec   = 1'b0;
    w_ded   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (r_cw[i]) w_syn = w_syn ^ 4'(i + 1);
    end
    w_pe = ^r_cw;
    if (w_syn == 4'd0) begin
      w_sec = w_pe;
    end else if (w_pe && (w_syn <= 4'd12)) begin
      w_sec = 1'b1;
      w_fixed[w_syn - 4'd1] = ~r_cw[w_syn - 4'd1];
    end else begin
      w_ded = 1'b1;
    end
    w_data = w_ded ? f_extract(r_cw) : f_extract(w_fixed);
  end

  // Next-state, handshake and scrub-pending logic
  always_comb begin
    w_state_nxt   = r_state;
    w_hs          = 1'b0;
    w_scrub_start = 1'b0;
    w_scrub_exit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_state_nxt   = S_SCRUB_RD;
          w_scrub_start = 1'b1;
        end else if (bus.req_valid && r_req_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = bus.req_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE:     w_state_nxt = S_IDLE;
      S_READ:      w_state_nxt = S_RDEC;
      S_RDEC:      w_state_nxt = S_IDLE;
      S_SCRUB_RD:  w_state_nxt = S_SCRUB_CHK;
      S_SCRUB_CHK: begin
        if (w_sec) begin
          w_state_nxt = S_SCRUB_WB;
        end else begin
          w_state_nxt  = S_IDLE;
          w_scrub_exit = 1'b1;
        end
      end
      S_SCRUB_WB: begin
        w_state_nxt  = S_IDLE;
        w_scrub_exit = 1'b1;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
    w_fire        = scrub_en && (r_timer == TMR_W'(SCRUB_INTERVAL - 1));
    w_pending_nxt = scrub_en && (w_fire || (r_pending && !w_scrub_start));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Scrub interval timer and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_timer   <= (!scrub_en || w_fire) ? '0 : r_timer + TMR_W'(1);
      r_pending <= w_pending_nxt;
    end
  end

  // Array, request latches, decode results, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mask       <= '0;
      r_cw         <= '0;
      r_scrub_ptr  <= '0;
      r_req_ready  <= 1'b1;
      r_scrub_busy <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_sec    <= 1'b0;
      r_rsp_ded    <= 1'b0;
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_req_ready  <= (w_state_nxt == S_IDLE) && !w_pending_nxt;
      r_scrub_busy <= (w_state_nxt == S_SCRUB_RD) || (w_state_nxt == S_SCRUB_CHK) ||
                      (w_state_nxt == S_SCRUB_WB);
      if (w_hs) begin
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_mask  <= bus.req_inj_mask;
      end
      if (w_scrub_start) begin
        r_addr <= r_scrub_ptr;
        r_mask <= '0;
      end
      case (r_state)
        S_WRITE, S_SCRUB_WB: r_mem[r_addr] <= f_encode(r_wdata) ^ r_mask;
        S_READ, S_SCRUB_RD:  r_cw <= r_mem[r_addr];
        S_RDEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_data;
          r_rsp_sec   <= w_sec;
          r_rsp_ded   <= w_ded;
        end
        S_SCRUB_CHK:         r_wdata <= w_data;
        default: ;
      endcase
      if ((r_state == S_RDEC) || (r_state == S_SCRUB_CHK)) begin
        if (w_sec && (r_sec_cnt != 8'hFF)) r_sec_cnt <= r_sec_cnt + 8'd1;
        if (w_ded && (r_ded_cnt != 8'hFF)) r_ded_cnt <= r_ded_cnt + 8'd1;
      end
      if (w_scrub_exit) r_scrub_ptr <= r_scrub_ptr + ADDR_W'(1);
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_sec   = r_rsp_sec;
  assign bus.rsp_ded   = r_rsp_ded;
  assign scrub_busy    = r_scrub_busy;
  assign sec_cnt       = r_sec_cnt;
  assign ded_cnt       = r_ded_cnt;
endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Directed bench for ecc_mem_ctrl with a read-response scoreboard.
module tb_ecc_mem_ctrl;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SI     = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scrub_en = 1'b0;
  logic       scrub_busy;
  logic [7:0] sec_cnt, ded_cnt;

  ecc_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ecc_mem_ctrl #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SI)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .scrub_en(scrub_en),
    .scrub_busy(scrub_busy), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sec;
    logic       ded;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, n_rsp = 0, scrub_total = 0, viol = 0, inter = 0;
  logic busy_q = 1'b0;

  logic [3:0] cont_addr [5] = '{4'd0, 4'd2, 4'd5, 4'd7, 4'd9};
  logic [7:0] cont_data [5] = '{8'hA5, 8'h3C, 8'h77, 8'h00, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard plus scrub/host interaction monitors
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_mon.data));
        chk("rsp_sec", 32'(bus.rsp_sec), 32'(e_mon.sec));
        chk("rsp_ded", 32'(bus.rsp_ded), 32'(e_mon.ded));
        chk("rsp_latency", 32'(cyc), 32'(e_mon.due));
      end
    end
    if (scrub_busy && bus.req_ready) viol++;
    if (scrub_busy && (sb.size() != 0)) inter++;
    if (scrub_busy && !busy_q) scrub_total++;
    busy_q = scrub_busy;
  end

  task automatic req(input logic we, input logic [3:0] a, input logic [7:0] d,
                     input logic [12:0] m, input logic [7:0] ed, input logic es,
                     input logic edd);
    int b;
    b = 0;
    @(negedge clk);
    while (!bus.req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_inj_mask = m;
    if (!we) sb.push_back('{data: ed, sec: es, ded: edd, due: cyc + 3});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [12:0] m);
    req(1'b1, a, d, m, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] ed, input logic es, input logic edd);
    req(1'b0, a, 8'h00, 13'h0, ed, es, edd);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("rsp_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, rsp0;
    logic acc;
    logic [7:0] sec0, ded0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_inj_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_sec_cnt", 32'(sec_cnt), 32'd0);
    chk("rst_ded_cnt", 32'(ded_cnt), 32'd0);
    chk("rst_scrub_busy", 32'(scrub_busy), 32'd0);

    // Clean write/read and stored codeword
    wr(4'd2, 8'h3C, 13'h0000);
    rd(4'd2, 8'h3C, 1'b0, 1'b0);
    drain();
    chk("cw_addr2", 32'(dut.r_mem[2]), 32'h1362);

    // Single-bit errors: data bit d1, then overall parity p0
    wr(4'd2, 8'h3C, 13'h0010);
    rd(4'd2, 8'h3C, 1'b1, 1'b0);
    drain();
    chk("sec_cnt_1", 32'(sec_cnt), 32'd1);
    wr(4'd2, 8'h3C, 13'h1000);
    rd(4'd2, 8'h3C, 1'b1, 1'b0);
    drain();
    chk("sec_cnt_2", 32'(sec_cnt), 32'd2);

    // Double error on d1,d2: raw data has both bits flipped (0x3C ^ 0x06)
    wr(4'd2, 8'h3C, 13'h0030);
    rd(4'd2, 8'h3A, 1'b0, 1'b1);
    drain();
    chk("ded_cnt_1", 32'(ded_cnt), 32'd1);
    chk("sec_cnt_hold", 32'(sec_cnt), 32'd2);

    // Back-to-back write/read and untouched address
    wr(4'd5, 8'h77, 13'h0000);
    rd(4'd5, 8'h77, 1'b0, 1'b0);
    rd(4'd7, 8'h00, 1'b0, 1'b0);
    wr(4'd9, 8'hFF, 13'h0000);
    rd(4'd9, 8'hFF, 1'b0, 1'b0);
    drain();

    // Scrub corrects d4 of addr 0 with write-back
    wr(4'd0, 8'hA5, 13'h0100);
    @(negedge clk);
    scrub_en = 1'b1;
    n = 0;
    while (!scrub_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scrub_start", 32'(scrub_busy), 32'd1);
    n = 0;
    while (scrub_busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    scrub_en = 1'b0;
    chk("scrub_busy_len", 32'(n), 32'd3);
    chk("scrub_sec_cnt", 32'(sec_cnt), 32'd3);
    rd(4'd0, 8'hA5, 1'b0, 1'b0);
    drain();

    // Continuous host reads with scrubbing enabled over a clean array
    wr(4'd2, 8'h3C, 13'h0000);
    @(negedge clk);
    sec0 = sec_cnt;
    ded0 = ded_cnt;
    rsp0 = n_rsp;
    viol = 0;
    inter = 0;
    scrub_en = 1'b1;
    k = 0;
    bus.req_we = 1'b0;
    bus.req_addr = cont_addr[0];
    bus.req_valid = 1'b1;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      acc = bus.req_ready;
      if (acc) sb.push_back('{data: cont_data[k], sec: 1'b0, ded: 1'b0, due: cyc + 3});
      @(posedge clk);
      #1;
      if (acc) begin
        k = (k + 1) % 5;
        bus.req_addr = cont_addr[k];
      end
    end
    bus.req_valid = 1'b0;
    scrub_en = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("ready_low_in_scrub", 32'(viol), 32'd0);
    chk("no_interleave", 32'(inter), 32'd0);
    chk("scrub_count_ge17", 32'(scrub_total >= 17), 32'd1);
    chk("scrub_ptr_wrap", 32'(dut.r_scrub_ptr), 32'(scrub_total % 16));
    chk("host_rsp_ge50", 32'((n_rsp - rsp0) >= 50), 32'd1);
    chk("cont_sec_cnt", 32'(sec_cnt), 32'(sec0));
    chk("cont_ded_cnt", 32'(ded_cnt), 32'(ded0));

    // Reset asserted while a read is in RDEC
    @(negedge clk);
    rsp0 = n_rsp;
    bus.req_we = 1'b0;
    bus.req_addr = 4'd5;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdec_no_rsp", 32'(n_rsp - rsp0), 32'd0);
    chk("rst_rdec_sec_cnt", 32'(sec_cnt), 32'd0);
    chk("rst_rdec_ded_cnt", 32'(ded_cnt), 32'd0);
    chk("rst_rdec_cw5", 32'(dut.r_mem[5]), 32'd0);
    rd(4'd5, 8'h00, 1'b0, 1'b0);
    rd(4'd2, 8'h00, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
